ps2_rx: RTL and testbench

PS/2 device-to-host serial receiver. Synchronizes and glitch-filters the raw `ps2_clk`/`ps2_data` pins, deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents each good byte with a one-cycle `rx_done` strobe. It sits directly upstream of the keyboard scan-code decoder, driving that block's `rx_done` and byte inputs.

---
 rtl/ps2_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_ps2_rx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 device-to-host serial receiver. Synchronizes and
//            glitch-filters the raw PS/2 clock/data pins. Deserializes
//            11-bit frames (start, 8 data bits LSB first, odd parity, stop).
//            Each good byte is presented with a one-cycle rx_done strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FILTER_LEN     : consecutive equal synchronized ps2_clk samples needed
//                    before the filtered clock changes level (2..255)
//   TIMEOUT_CYCLES : max clk cycles between falling edges inside a frame
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   ps2_clk  in   raw PS/2 clock pin (asynchronous)
//   ps2_data in   raw PS/2 data pin (asynchronous)
//   rx_data  out  [7:0] last good byte received
//   rx_done  out  one-cycle pulse, rx_data valid
//   rx_err   out  one-cycle pulse, frame rejected (stop/parity/timeout)
//   busy     out  high while a frame is in progress
// Build option
//   PS2_RX_PARITY_CHECK_EN : when defined, a parity mismatch rejects the
//                            frame; otherwise the parity bit is ignored.
// ============================================================================
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err,
  output logic       busy
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_SAT   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_d;

  logic          clk_meta;
  logic          clk_sync;
  logic          data_meta;
  logic          data_sync;

  logic [7:0]    filt_cnt;
  logic          clk_filt;
  logic          clk_filt_d;
  logic          fall;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          parity_ok;

  logic          start;
  logic          shift_en;
  logic          done_set;
  logic          err_set;

  // --------------------------------------------------------------------------
  // Two-stage synchronizers; idle-high reset value so a reset never looks
  // like a falling clock edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Glitch filter: the counter tracks how many consecutive samples disagree
  // with the filtered level; any agreeing sample restarts the count.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // --------------------------------------------------------------------------
  // Inter-edge timeout. Held at zero while idle, cleared by each edge,
  // saturating so a stuck frame can never wrap back below the limit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state == IDLE) || fall) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_SAT) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt >= TMO_LAST);

  // --------------------------------------------------------------------------
  // Parity evaluation
  // --------------------------------------------------------------------------
`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit <= 1'b0;
    end else if ((state == PARITY) && fall) begin
      par_bit <= data_sync;
    end
  end

  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    start    = 1'b0;
    shift_en = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    if (tmo_hit) begin
      state_d = IDLE;
      err_set = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // A falling edge with data high is not a start bit.
          if (fall && !data_sync) begin
            state_d = DATA;
            start   = 1'b1;
          end
        end
        DATA: begin
          if (fall) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            state_d = STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state_d = IDLE;
            if (data_sync && parity_ok) begin
              done_set = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_done <= done_set;
      rx_err  <= err_set;
      if (start) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        shreg[bit_cnt] <= data_sync;
        bit_cnt        <= bit_cnt + 3'd1;
      end
      if (done_set) begin
        rx_data <= shreg;
      end
    end
  end

  // Decoded from the state register so it drops together with the strobes.
  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx
// Purpose  : Self-checking bench for ps2_rx. Drives PS/2 frames on the raw
//            pins with a scaled-down bit period. Compares strobes and data
//            against a frame-level model of the receive rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HALF           = 40;   // PS/2 half bit period in clk cycles

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       busy;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc           = 0;
  int unsigned last_fall_cyc = 0;
  int unsigned err_cyc       = 0;
  int          done_cnt      = 0;
  int          err_cnt       = 0;
  int          overlap_cnt   = 0;
  int          busy_viol     = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_data      = 8'h00;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the opposite edge.
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt <= done_cnt + 1;
      got_q.push_back(rx_data);
    end
    if (rx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (rx_done && rx_err) overlap_cnt <= overlap_cnt + 1;
    if ((rx_done || rx_err) && busy) busy_viol <= busy_viol + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Reference model: frame accepted iff stop bit is 1 and (when checking is
  // built in) data plus parity bit carry an odd count of ones.
  // --------------------------------------------------------------------------
  function automatic bit frame_good(input logic [7:0] d, input bit par, input bit stop);
    bit par_ok;
    par_ok = (($countones({d, par}) % 2) == 1);
`ifdef PS2_RX_PARITY_CHECK_EN
    return stop && par_ok;
`else
    return stop && (par_ok || !par_ok);
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One bit: data set while clock high, then clock low for half a period.
  task automatic send_bit(input bit b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      tick(12);
      ps2_clk = 1'b0;
      tick(FILTER_LEN - 1);
      ps2_clk = 1'b1;
      tick(HALF - 12 - (FILTER_LEN - 1));
    end else begin
      tick(HALF);
    end
    ps2_clk       = 1'b0;
    last_fall_cyc = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop,
                            input int glitch_bit, output bit par);
    logic [10:0] bits;
    par  = (($countones(d) % 2) == 0) ^ par_flip;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_bit);
    ps2_data = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    vectors++; if (rx_done !== 1'b0) begin miscompares++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    vectors++; if (rx_err !== 1'b0) begin miscompares++; $display("FAIL reset_rx_err: got %b want 0", rx_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_single;
    int d0, e0;
    bit par, good;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h1D, 1'b0, 1'b1, -1, par);
    tick(5);
    good = frame_good(8'h1D, par, 1'b1);
    if (good) exp_data = 8'h1D;
    vectors++; if (done_cnt - d0 !== int'(good)) begin miscompares++; $display("FAIL single_done_count: got %0d want %0d", done_cnt - d0, int'(good)); end
    vectors++; if (err_cnt - e0 !== int'(!good)) begin miscompares++; $display("FAIL single_err_count: got %0d want %0d", err_cnt - e0, int'(!good)); end
    vectors++; if (rx_data !== exp_data) begin miscompares++; $display("FAIL single_rx_data: got %h want %h", rx_data, exp_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int e0;
    bit par;
    e0 = err_cnt;
    got_q.delete();
    send_frame(8'hF0, 1'b0, 1'b1, -1, par);
    send_frame(8'h1C, 1'b0, 1'b1, -1, par);
    tick(5);
    exp_data = 8'h1C;
    vectors++; if (got_q.size() !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 8'hF0) begin miscompares++; $display("FAIL b2b_first: got %h want f0", got_q[0]); end
      vectors++; if (got_q[1] !== 8'h1C) begin miscompares++; $display("FAIL b2b_second: got %h want 1c", got_q[1]); end
    end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_parity;
    int d0, e0;
    bit par, good;
    logic [7:0] pre;
    pre = 8'($urandom_range(0, 127)) | 8'h80;
    send_frame(pre, 1'b0, 1'b1, -1, par);
    tick(5);
    exp_data = pre;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, -1, par);
    tick(5);
    good = frame_good(8'h1C, par, 1'b1);
    if (good) exp_data = 8'h1C;
    vectors++; if (done_cnt - d0 !== int'(good)) begin miscompares++; $display("FAIL parity_done: got %0d want %0d", done_cnt - d0, int'(good)); end
    vectors++; if (err_cnt - e0 !== int'(!good)) begin miscompares++; $display("FAIL parity_err: got %0d want %0d", err_cnt - e0, int'(!good)); end
    vectors++; if (rx_data !== exp_data) begin miscompares++; $display("FAIL parity_rx_data: got %h want %h", rx_data, exp_data); end
  endtask

  task automatic test_stop_err;
    int d0, e0;
    bit par;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h23, 1'b0, 1'b0, -1, par);
    tick(5);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL stop_err_pulse: got %0d want 1", err_cnt - e0); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL stop_err_no_done: got %0d want 0", done_cnt - d0); end
    vectors++; if (rx_data !== exp_data) begin miscompares++; $display("FAIL stop_err_rx_data: got %h want %h", rx_data, exp_data); end
    d0 = done_cnt;
    send_frame(8'h23, 1'b0, 1'b1, -1, par);
    tick(5);
    exp_data = 8'h23;
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL stop_recover_done: got %0d want 1", done_cnt - d0); end
    vectors++; if (rx_data !== 8'h23) begin miscompares++; $display("FAIL stop_recover_data: got %h want 23", rx_data); end
  endtask

  task automatic test_glitch;
    int d0, e0;
    bit par;
    d0 = done_cnt; e0 = err_cnt;
    // Data low during the idle glitch: a passed glitch would look like a start.
    ps2_data = 1'b0;
    tick(10);
    ps2_clk = 1'b0;
    tick(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    tick(20);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle_busy: got %b want 0", busy); end
    ps2_data = 1'b1;
    tick(20);
    send_frame(8'h2D, 1'b0, 1'b1, 4, par);
    tick(5);
    exp_data = 8'h2D;
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL glitch_done: got %0d want 1", done_cnt - d0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
    vectors++; if (rx_data !== 8'h2D) begin miscompares++; $display("FAIL glitch_rx_data: got %h want 2d", rx_data); end
  endtask

  task automatic test_timeout;
    int d0, e0, waited, lat;
    bit par;
    logic [7:0] d;
    d  = 8'($urandom);
    d0 = done_cnt; e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i], 1'b0);
    ps2_data = 1'b1;
    waited = 0;
    while ((err_cnt == e0) && (waited < TIMEOUT_CYCLES + 100)) begin
      tick(1);
      waited++;
    end
    tick(1);
    lat = int'(err_cyc - last_fall_cyc);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL timeout_err_pulse: got %0d want 1", err_cnt - e0); end
    // Pin-to-edge latency (2 sync + FILTER_LEN + 1) plus the timeout, +/-1.
    vectors++; if ((lat < TIMEOUT_CYCLES + FILTER_LEN + 2) || (lat > TIMEOUT_CYCLES + FILTER_LEN + 4)) begin
      miscompares++; $display("FAIL timeout_latency: got %0d want %0d..%0d", lat, TIMEOUT_CYCLES + FILTER_LEN + 2, TIMEOUT_CYCLES + FILTER_LEN + 4);
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b want 0", busy); end
    vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL timeout_no_done: got %0d want 0", done_cnt - d0); end
    send_frame(8'h05, 1'b0, 1'b1, -1, par);
    tick(5);
    exp_data = 8'h05;
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL timeout_recover_done: got %0d want 1", done_cnt - d0); end
    vectors++; if (rx_data !== 8'h05) begin miscompares++; $display("FAIL timeout_recover_data: got %h want 05", rx_data); end
  endtask

  task automatic test_reset_midframe;
    int d0, e0;
    bit par;
    logic [7:0] d;
    d  = 8'($urandom);
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(d[i], 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
    #1 reset = 1'b1;
    tick(2);
    exp_data = 8'h00;
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rst_mid_rx_data: got %h want 00", rx_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick(TIMEOUT_CYCLES + 60);
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL rst_mid_no_err: got %0d want 0", err_cnt - e0); end
    d0 = done_cnt;
    d  = 8'($urandom);
    send_frame(d, 1'b0, 1'b1, -1, par);
    tick(5);
    exp_data = d;
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rst_mid_recover_done: got %0d want 1", done_cnt - d0); end
    vectors++; if (rx_data !== d) begin miscompares++; $display("FAIL rst_mid_recover_data: got %h want %h", rx_data, d); end
  endtask

  task automatic test_random;
    int d0, e0, kind;
    bit par, stop, good;
    logic [7:0] d;
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 2);
      stop = (kind != 2);
      d0 = done_cnt; e0 = err_cnt;
      send_frame(d, kind == 1, stop, -1, par);
      tick(5);
      good = frame_good(d, par, stop);
      if (good) exp_data = d;
      vectors++; if (done_cnt - d0 !== int'(good)) begin miscompares++; $display("FAIL random_done[%0d]: got %0d want %0d", n, done_cnt - d0, int'(good)); end
      vectors++; if (err_cnt - e0 !== int'(!good)) begin miscompares++; $display("FAIL random_err[%0d]: got %0d want %0d", n, err_cnt - e0, int'(!good)); end
      vectors++; if (rx_data !== exp_data) begin miscompares++; $display("FAIL random_rx_data[%0d]: got %h want %h", n, rx_data, exp_data); end
    end
  endtask

  task automatic test_strobe_rules;
    vectors++; if (overlap_cnt !== 0) begin miscompares++; $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt); end
    vectors++; if (busy_viol !== 0) begin miscompares++; $display("FAIL strobe_busy_low: got %0d want 0", busy_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_stop_err();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_strobe_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
